// File: rtl/id_stage_if.sv
// id_stage_if: decode-stage bus; master is the fetch/execute side, slave is id_stage.
interface id_stage_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic [15:0]           instr_i;
  logic [ADDR_WIDTH-1:0] pcd_i;
  logic                  wb_en_i;
  logic [2:0]            wb_addr_i;
  logic [DATA_WIDTH-1:0] wb_data_i;
  logic                  exmem_regwrite_i;
  logic [2:0]            exmem_rd_i;
  logic                  stallPC_o;
  logic                  stallIF_ID_o;
  logic                  flushIF_ID_o;
  logic                  PC_src_o;
  logic                  jump_o;
  logic [ADDR_WIDTH-1:0] branchAddr_o;
  logic [ADDR_WIDTH-1:0] jumpAddr_o;
  logic [DATA_WIDTH-1:0] idex_rs_data_o;
  logic [DATA_WIDTH-1:0] idex_rt_data_o;
  logic [DATA_WIDTH-1:0] idex_imm_o;
  logic [2:0]            idex_rs_o;
  logic [2:0]            idex_rt_o;
  logic [2:0]            idex_rd_o;
  logic                  idex_regwrite_o;
  logic                  idex_memread_o;
  logic                  idex_memwrite_o;
  logic                  idex_alusrc_o;
  logic [2:0]            idex_aluop_o;
  modport master (
    output instr_i, pcd_i, wb_en_i, wb_addr_i, wb_data_i, exmem_regwrite_i, exmem_rd_i,
    input  stallPC_o, stallIF_ID_o, flushIF_ID_o, PC_src_o, jump_o, branchAddr_o, jumpAddr_o,
    input  idex_rs_data_o, idex_rt_data_o, idex_imm_o, idex_rs_o, idex_rt_o, idex_rd_o,
    input  idex_regwrite_o, idex_memread_o, idex_memwrite_o, idex_alusrc_o, idex_aluop_o
  );
  modport slave (
    input  instr_i, pcd_i, wb_en_i, wb_addr_i, wb_data_i, exmem_regwrite_i, exmem_rd_i,
    output stallPC_o, stallIF_ID_o, flushIF_ID_o, PC_src_o, jump_o, branchAddr_o, jumpAddr_o,
    output idex_rs_data_o, idex_rt_data_o, idex_imm_o, idex_rs_o, idex_rt_o, idex_rd_o,
    output idex_regwrite_o, idex_memread_o, idex_memwrite_o, idex_alusrc_o, idex_aluop_o
  );
endinterface

// File: rtl/id_stage.sv
// id_stage: IF/ID register, register file, decode, hazard stall, branch/jump resolution, ID/EX register.
// Define ID_WB_BYPASS_EN for write-through register reads instead of stalling on a same-cycle write-back.
module id_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input logic     clk,
  input logic     rst,
  id_stage_if.slave bus
);
  typedef struct packed {
    logic                  regwrite;
    logic                  memread;
    logic                  memwrite;
    logic                  alusrc;
    logic [2:0]            aluop;
    logic [2:0]            rs;
    logic [2:0]            rt;
    logic [2:0]            rd;
    logic [DATA_WIDTH-1:0] rs_data;
    logic [DATA_WIDTH-1:0] rt_data;
    logic [DATA_WIDTH-1:0] imm;
  } idex_t;
  logic [15:0]           r_instr;
  logic [DATA_WIDTH-1:0] r_rf [8];
  idex_t                 r_idex;
  idex_t                 w_idex_d;
  logic [3:0]            w_op;
  logic [2:0]            w_rd, w_rs, w_rt, w_funct;
  logic [DATA_WIDTH-1:0] w_imm, w_rs_data, w_rt_data;
  logic                  w_rtype, w_addi, w_lw, w_sw, w_beq, w_jmp;
  logic                  w_use_rs, w_use_rt, w_regwrite, w_alusrc;
  logic [2:0]            w_aluop;
  logic                  w_load_use, w_branch_haz, w_wb_haz, w_stall, w_pc_src, w_flush;
  assign w_op    = r_instr[15:12];
  assign w_rd    = r_instr[11:9];
  assign w_rs    = r_instr[8:6];
  assign w_rt    = r_instr[5:3];
  assign w_funct = r_instr[2:0];
  assign w_imm   = {{(DATA_WIDTH-6){r_instr[5]}}, r_instr[5:0]};
  assign w_rtype = w_op == 4'd0;
  assign w_addi  = w_op == 4'd1;
  assign w_lw    = w_op == 4'd2;
  assign w_sw    = w_op == 4'd3;
  assign w_beq   = w_op == 4'd4;
  assign w_jmp   = w_op == 4'd5;
  assign w_use_rs   = w_rtype | w_addi | w_lw | w_sw | w_beq;
  assign w_use_rt   = w_rtype | w_sw | w_beq;
  assign w_regwrite = (w_rtype | w_addi | w_lw) && w_rd != 3'd0;
  assign w_alusrc   = w_addi | w_lw | w_sw;
  assign w_aluop    = w_rtype ? w_funct : 3'd0;
`ifdef ID_WB_BYPASS_EN
  assign w_rs_data = w_rs == 3'd0 ? '0 : (bus.wb_en_i && bus.wb_addr_i == w_rs) ? bus.wb_data_i : r_rf[w_rs];
  assign w_rt_data = w_rt == 3'd0 ? '0 : (bus.wb_en_i && bus.wb_addr_i == w_rt) ? bus.wb_data_i : r_rf[w_rt];
  assign w_wb_haz  = 1'b0;
`else
  assign w_rs_data = w_rs == 3'd0 ? '0 : r_rf[w_rs];
  assign w_rt_data = w_rt == 3'd0 ? '0 : r_rf[w_rt];
  assign w_wb_haz  = bus.wb_en_i && bus.wb_addr_i != 3'd0 &&
                     ((w_use_rs && bus.wb_addr_i == w_rs) || (w_use_rt && bus.wb_addr_i == w_rt));
`endif
  assign w_load_use = r_idex.memread && r_idex.rd != 3'd0 &&
                      ((w_use_rs && r_idex.rd == w_rs) || (w_use_rt && r_idex.rd == w_rt));
  // branches compare in ID, so any in-flight producer of an operand must drain first
  assign w_branch_haz = w_beq &&
    ((r_idex.regwrite && r_idex.rd != 3'd0 && (r_idex.rd == w_rs || r_idex.rd == w_rt)) ||
     (bus.exmem_regwrite_i && bus.exmem_rd_i != 3'd0 && (bus.exmem_rd_i == w_rs || bus.exmem_rd_i == w_rt)));
  assign w_stall  = w_load_use | w_branch_haz | w_wb_haz;
  assign w_pc_src = w_beq && w_rs_data == w_rt_data && !w_stall;
  assign w_flush  = w_pc_src | w_jmp;
  assign w_idex_d = {w_regwrite, w_lw, w_sw, w_alusrc, w_aluop, w_rs, w_rt, w_rd, w_rs_data, w_rt_data, w_imm};
  assign bus.stallPC_o       = w_stall;
  assign bus.stallIF_ID_o    = w_stall;
  assign bus.PC_src_o        = w_pc_src;
  assign bus.jump_o          = w_jmp;
  assign bus.flushIF_ID_o    = w_flush;
  assign bus.branchAddr_o    = bus.pcd_i + w_imm[ADDR_WIDTH-1:0];
  assign bus.jumpAddr_o      = ADDR_WIDTH'(r_instr[7:0]);
  assign bus.idex_regwrite_o = r_idex.regwrite;
  assign bus.idex_memread_o  = r_idex.memread;
  assign bus.idex_memwrite_o = r_idex.memwrite;
  assign bus.idex_alusrc_o   = r_idex.alusrc;
  assign bus.idex_aluop_o    = r_idex.aluop;
  assign bus.idex_rs_o       = r_idex.rs;
  assign bus.idex_rt_o       = r_idex.rt;
  assign bus.idex_rd_o       = r_idex.rd;
  assign bus.idex_rs_data_o  = r_idex.rs_data;
  assign bus.idex_rt_data_o  = r_idex.rt_data;
  assign bus.idex_imm_o      = r_idex.imm;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_instr <= '0;
      r_idex  <= '0;
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
    end else begin
      r_instr <= w_stall ? r_instr : w_flush ? 16'h0000 : bus.instr_i;
      r_idex  <= w_stall ? '0 : w_idex_d;
      if (bus.wb_en_i && bus.wb_addr_i != 3'd0) r_rf[bus.wb_addr_i] <= bus.wb_data_i;
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed scenarios plus random instruction streams checked against a behavioural decode model.
`timescale 1ns/1ps
module tb_id_stage;
  logic clk = 1'b0;
  logic rst;
  int   errs = 0;
  int   checks = 0;
  always #5 clk = ~clk;
  id_stage_if bus ();
  id_stage dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    bit rw, mr, mw, as;
    bit [2:0] aluop, rs, rt, rd;
    bit [15:0] rsd, rtd, imm;
  } ex_t;
  bit [15:0] m_rf [8];
  bit [15:0] m_ifid;
  ex_t       m_ex, e_ex;
  bit        m_mem_rw;
  bit [2:0]  m_mem_rd;
  bit        e_stall, e_pcsrc, e_jump;
  bit [7:0]  e_baddr, e_jaddr;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit [15:0] reg_val(input bit [2:0] a);
    if (a == 3'd0) return 16'h0;
`ifdef ID_WB_BYPASS_EN
    if (bus.wb_en_i && bus.wb_addr_i == a) return bus.wb_data_i;
`endif
    return m_rf[a];
  endfunction
  // a source is unavailable while its producer is still upstream of the register file
  function automatic bit blocked(input bit [2:0] a, input bit is_branch);
    if (a == 3'd0) return 1'b0;
    if (m_ex.mr && m_ex.rd == a) return 1'b1;
    if (is_branch && ((m_ex.rw && m_ex.rd == a) || (bus.exmem_regwrite_i && bus.exmem_rd_i == a))) return 1'b1;
`ifndef ID_WB_BYPASS_EN
    if (bus.wb_en_i && bus.wb_addr_i == a) return 1'b1;
`endif
    return 1'b0;
  endfunction
  task automatic predict;
    bit [3:0]  op   = m_ifid[15:12];
    bit [2:0]  d    = m_ifid[11:9];
    bit [2:0]  s    = m_ifid[8:6];
    bit [2:0]  t    = m_ifid[5:3];
    bit [15:0] imm  = {{10{m_ifid[5]}}, m_ifid[5:0]};
    bit        alu  = op == 4'd0;
    bit        addi = op == 4'd1;
    bit        lw   = op == 4'd2;
    bit        sw   = op == 4'd3;
    bit        beq  = op == 4'd4;
    bit [15:0] sv   = reg_val(s);
    bit [15:0] tv   = reg_val(t);
    e_stall = ((alu | addi | lw | sw | beq) && blocked(s, beq)) || ((alu | sw | beq) && blocked(t, beq));
    e_pcsrc = beq && sv == tv && !e_stall;
    e_jump  = op == 4'd5;
    e_baddr = bus.pcd_i + imm[7:0];
    e_jaddr = m_ifid[7:0];
    e_ex = '{default: 0};
    if (!e_stall) begin
      e_ex.rw = (alu | addi | lw) && d != 3'd0;
      e_ex.mr = lw;
      e_ex.mw = sw;
      e_ex.as = addi | lw | sw;
      e_ex.aluop = alu ? m_ifid[2:0] : 3'd0;
      e_ex.rs = s;
      e_ex.rt = t;
      e_ex.rd = d;
      e_ex.rsd = sv;
      e_ex.rtd = tv;
      e_ex.imm = imm;
    end
  endtask
  task automatic compare;
    check("stallPC", bus.stallPC_o, e_stall);
    check("stallIF_ID", bus.stallIF_ID_o, e_stall);
    check("PC_src", bus.PC_src_o, e_pcsrc);
    check("jump", bus.jump_o, e_jump);
    check("flushIF_ID", bus.flushIF_ID_o, e_pcsrc | e_jump);
    check("branchAddr", bus.branchAddr_o, e_baddr);
    check("jumpAddr", bus.jumpAddr_o, e_jaddr);
    check("idex_regwrite", bus.idex_regwrite_o, m_ex.rw);
    check("idex_memread", bus.idex_memread_o, m_ex.mr);
    check("idex_memwrite", bus.idex_memwrite_o, m_ex.mw);
    check("idex_alusrc", bus.idex_alusrc_o, m_ex.as);
    check("idex_aluop", bus.idex_aluop_o, m_ex.aluop);
    check("idex_rs", bus.idex_rs_o, m_ex.rs);
    check("idex_rt", bus.idex_rt_o, m_ex.rt);
    check("idex_rd", bus.idex_rd_o, m_ex.rd);
    check("idex_rs_data", bus.idex_rs_data_o, m_ex.rsd);
    check("idex_rt_data", bus.idex_rt_data_o, m_ex.rtd);
    check("idex_imm", bus.idex_imm_o, m_ex.imm);
  endtask
  task automatic clear_model;
    m_rf = '{default: 0};
    m_ifid = 16'h0;
    m_ex = '{default: 0};
    m_mem_rw = 1'b0;
    m_mem_rd = 3'd0;
  endtask
  task automatic settle;
    #1;
    if (rst) clear_model();
    predict();
    compare();
  endtask
  task automatic tick;
    @(posedge clk);
    if (rst) clear_model();
    else begin
      m_mem_rw = m_ex.rw;
      m_mem_rd = m_ex.rd;
      if (bus.wb_en_i && bus.wb_addr_i != 3'd0) m_rf[bus.wb_addr_i] = bus.wb_data_i;
      if (!e_stall) m_ifid = (e_pcsrc || e_jump) ? 16'h0 : bus.instr_i;
      m_ex = e_ex;
    end
    @(negedge clk);
  endtask
  task automatic drive(input bit [15:0] instr, input bit [7:0] pcd = 8'h0, input bit wen = 1'b0,
                       input bit [2:0] wa = 3'd0, input bit [15:0] wd = 16'h0);
    bus.instr_i = instr;
    bus.pcd_i = pcd;
    bus.wb_en_i = wen;
    bus.wb_addr_i = wa;
    bus.wb_data_i = wd;
    bus.exmem_regwrite_i = m_mem_rw;
    bus.exmem_rd_i = m_mem_rd;
  endtask
  task automatic step(input bit [15:0] instr, input bit [7:0] pcd = 8'h0, input bit wen = 1'b0,
                      input bit [2:0] wa = 3'd0, input bit [15:0] wd = 16'h0);
    drive(instr, pcd, wen, wa, wd);
    settle();
    tick();
  endtask
  function automatic bit [15:0] enc_r(input bit [3:0] op, input bit [2:0] d, s, t, f);
    return {op, d, s, t, f};
  endfunction
  function automatic bit [15:0] enc_i(input bit [3:0] op, input bit [2:0] d, s, input bit [5:0] imm);
    return {op, d, s, imm};
  endfunction
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit        taken;
    bit [15:0] ins;
    rst = 1'b1;
    clear_model();
    drive(16'h0);
    @(negedge clk);
    settle();
    tick();
    rst = 1'b0;
    // load-use: LW r2 then ADD r3,r2,r1
    step(enc_i(4'd2, 3'd2, 3'd1, 6'd0));
    step(enc_r(4'd0, 3'd3, 3'd2, 3'd1, 3'd0));
    drive(16'h0); settle();
    check("lu_stallPC", bus.stallPC_o, 1);
    check("lu_stallIF_ID", bus.stallIF_ID_o, 1);
    tick();
    drive(16'h0); settle();
    check("lu_bubble_memread", bus.idex_memread_o, 0);
    check("lu_released", bus.stallPC_o, 0);
    tick();
    drive(16'h0); settle();
    check("lu_issue_rs", bus.idex_rs_o, 2);
    tick();
    // taken BEQ with wrap-around target; the rt field overlaps imm6, so r7 carries the compared value
    step(16'h0, 8'h0, 1'b1, 3'd1, 16'd5);
    step(16'h0, 8'h0, 1'b1, 3'd2, 16'd5);
    step(16'h0, 8'h0, 1'b1, 3'd7, 16'd5);
    step(enc_i(4'd4, 3'd0, 3'd1, 6'b111101));
    drive(enc_r(4'd0, 3'd3, 3'd1, 3'd2, 3'd0), 8'h02); settle();
    check("beq_pcsrc", bus.PC_src_o, 1);
    check("beq_target", bus.branchAddr_o, 8'hFF);
    check("beq_flush", bus.flushIF_ID_o, 1);
    tick();
    step(16'h0);
    drive(16'h0); settle();
    check("beq_flushed_rd", bus.idex_rd_o, 0);
    tick();
    // jump
    step(16'h5040);
    drive(enc_i(4'd1, 3'd6, 3'd1, 6'd1)); settle();
    check("jmp_jump", bus.jump_o, 1);
    check("jmp_target", bus.jumpAddr_o, 8'h40);
    check("jmp_flush", bus.flushIF_ID_o, 1);
    tick();
    drive(16'h0); settle();
    check("jmp_bubble_regwrite", bus.idex_regwrite_o, 0);
    check("jmp_bubble_memwrite", bus.idex_memwrite_o, 0);
    tick();
    // branch hazard: ADDI r4,r1,-5 (=0) then BEQ r4,r0
    step(16'h0, 8'h0, 1'b1, 3'd4, 16'd9);
    step(enc_i(4'd1, 3'd4, 3'd1, 6'b111011));
    step(enc_i(4'd4, 3'd0, 3'd4, 6'b000010));
    drive(16'h0); settle();
    check("bh_stall_idex", bus.stallPC_o, 1);
    tick();
    drive(16'h0); settle();
    check("bh_stall_exmem", bus.stallPC_o, 1);
    tick();
    taken = 1'b0;
    for (int i = 0; i < 4 && !taken; i++) begin
      if (i == 0) drive(16'h0, 8'h10, 1'b1, 3'd4, 16'h0);
      else drive(16'h0, 8'h10);
      settle();
      taken = bus.PC_src_o;
      tick();
    end
    check("bh_resolved", taken, 1);
    // same-cycle write-back of a source register
    step(enc_r(4'd0, 3'd5, 3'd3, 3'd0, 3'd0));
    drive(16'h0, 8'h0, 1'b1, 3'd3, 16'hBEEF); settle();
`ifdef ID_WB_BYPASS_EN
    check("wb_no_stall", bus.stallPC_o, 0);
    tick();
`else
    check("wb_stall", bus.stallPC_o, 1);
    tick();
    drive(16'h0); settle();
    check("wb_stall_clear", bus.stallPC_o, 0);
    tick();
`endif
    drive(16'h0); settle();
    check("wb_rs_data", bus.idex_rs_data_o, 16'hBEEF);
    tick();
    // reset during a load-use stall
    step(enc_i(4'd2, 3'd6, 3'd0, 6'd0));
    step(enc_r(4'd0, 3'd1, 3'd6, 3'd6, 3'd0));
    drive(16'h0); settle();
    check("pre_rst_stall", bus.stallPC_o, 1);
    #2 rst = 1'b1;
    settle();
    check("rst_stall_cleared", bus.stallPC_o, 0);
    check("rst_idex_rs", bus.idex_rs_o, 0);
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      drive(i <= 7 ? enc_r(4'd0, 3'd1, 3'(i), 3'(i), 3'd0) : 16'h0);
      settle();
      if (i >= 3) check("rst_rf_read", bus.idex_rs_data_o, 0);
      tick();
    end
    // random streams
    for (int c = 0; c < 2000; c++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 3) != 0) ins[15:12] = 4'($urandom_range(0, 5));
      drive(ins, 8'($urandom), 1'($urandom_range(0, 1)), 3'($urandom),
            $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'($urandom_range(0, 3)));
      bus.exmem_regwrite_i = 1'($urandom);
      bus.exmem_rd_i = 3'($urandom);
      rst = $urandom_range(0, 299) == 0;
      settle();
      tick();
      rst = 1'b0;
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameters: DATA_WIDTH, 16, register/datapath width; ADDR_WIDTH, 8, instruction address width.
REQ-002 Ports: clk in 1, the one clock; rst in 1, asynchronous active-high reset; instr_i in 16, IM read data for the current fetch address; pcd_i in ADDR_WIDTH, PC+1 from IF/ID.
REQ-003 Ports: wb_en_i in 1, wb_addr_i in 3, wb_data_i in 16, write-back port; exmem_regwrite_i in 1, exmem_rd_i in 3, EX/MEM destination info.
REQ-004 Ports to IF: stallPC_o out 1, stallIF_ID_o out 1, flushIF_ID_o out 1, PC_src_o out 1, jump_o out 1, branchAddr_o out ADDR_WIDTH, jumpAddr_o out ADDR_WIDTH.
REQ-005 Ports to EX: idex_rs_data_o out 16, idex_rt_data_o out 16, idex_imm_o out 16, idex_rs_o/idex_rt_o/idex_rd_o out 3 each, idex_regwrite_o, idex_memread_o, idex_memwrite_o, idex_alusrc_o out 1 each, idex_aluop_o out 3.

Function
REQ-006 Instruction fields: op[15:12], rd[11:9], rs[8:6], rt[5:3], funct[2:0], imm6[5:0] sign-extended to 16 bits, jaddr[7:0].
REQ-007 Opcodes: 0000 R-type (aluop=funct, rs/rt used); 0001 ADDI (rd<=rs+imm, alusrc=1); 0010 LW (memread, rd written); 0011 SW (memwrite, rs base, rt data); 0100 BEQ (rs,rt compared); 0101 JMP; all others decode as NOP.
REQ-008 Internal IF/ID instruction register: reset 16'h0000; holds when stallIF_ID_o=1; loads 16'h0000 when flushIF_ID_o=1 and not stalled; else loads instr_i; same priority order as IF/ID PC register.
REQ-009 Register file: 8 x 16, r0 reads 0 always, writes to r0 ignored; write on clk rising edge when wb_en_i=1.
REQ-010 Decoded regwrite is forced 0 when rd=0.
REQ-011 BEQ: branchAddr_o = pcd_i + imm6[ADDR_WIDTH-1:0] (mod 2^ADDR_WIDTH, wrap-around); PC_src_o=1 when operands equal and no stall.
REQ-012 JMP: jump_o=1, jumpAddr_o=jaddr; no stall condition applies.
REQ-013 flushIF_ID_o = PC_src_o OR jump_o, combinational, same cycle as decode.
REQ-014 Load-use hazard: idex_memread_o=1 and idex_rd_o!=0 and equals a used source (rs or rt) -> stall.
REQ-015 Branch hazard: BEQ with idex_regwrite_o=1 or exmem_regwrite_i=1 whose rd (nonzero) matches rs or rt -> stall; PC_src_o=0 while stalled.
REQ-016 Stall: stallPC_o=stallIF_ID_o=1, flushIF_ID_o=0, ID/EX loads a bubble (all control bits 0, data/addresses 0).
REQ-017 ID/EX register: registered, one-cycle latency from IF/ID instruction to idex_* outputs; BEQ/JMP/NOP produce bubble control (regwrite/memread/memwrite 0).
REQ-018 Simultaneous stall and taken branch is impossible by REQ-015; stall has priority over jump never arising (jump never stalls).

Reset
REQ-019 rst asserted: IF/ID instruction 0, all ID/EX outputs 0, all 8 registers 0, immediately (asynchronous).
REQ-020 rst deasserted: combinational outputs derive from NOP; stallPC_o, stallIF_ID_o, flushIF_ID_o, PC_src_o, jump_o all 0.
REQ-021 rst mid-stall clears the stall; first post-reset cycle decodes NOP.

Configuration
REQ-022 Macro ID_WB_BYPASS_EN defined: register read of the address being written this cycle with wb_en_i=1 returns wb_data_i (write-through).
REQ-023 ID_WB_BYPASS_EN undefined: no bypass; hazard unit additionally stalls when wb_en_i=1 and wb_addr_i (nonzero) matches a used source register.

Verification
REQ-024 Reset: rst=1 mid-run -> all idex_* = 0, r1..r7 read 0, all control outputs 0.
REQ-025 LW r2 then ADD r3,r2,r1 -> one cycle stallPC_o=stallIF_ID_o=1, bubble in ID/EX, ADD issues next cycle with idex_rs_o=2.
REQ-026 r1=r2=5, BEQ r1,r2,imm6=-3, pcd_i=8'h02 -> PC_src_o=1, branchAddr_o=8'hFF, flushIF_ID_o=1, next IF/ID instruction 0.
REQ-027 JMP jaddr=8'h40 -> jump_o=1, jumpAddr_o=8'h40, flushIF_ID_o=1, ID/EX bubble.
REQ-028 ADDI r4 followed by BEQ r4,r0 -> stall while idex/exmem rd=4, branch resolves after hazard clears.
REQ-029 wb_en_i=1, wb_addr_i=3, wb_data_i=16'hBEEF with ADD reading r3 same cycle -> with ID_WB_BYPASS_EN idex_rs_data_o=16'hBEEF next cycle, no stall; without it one stall cycle then 16'hBEEF.
